// File: rtl/dma_ch_sched_pkg.sv
// -----------------------------------------------------------------------------
// dma_sched_pkg
// Shared types and helpers for the DMA channel command scheduler.
//   state_e   : scheduler FSM state (IDLE = arbitrating, ISSUE = command held)
//   CH_IDX_W  : width of the AXI ID / channel index fields (covers up to 16 ch)
//   flat_lo() : low bit offset of element 'idx' in a flattened vector
// -----------------------------------------------------------------------------
package dma_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int CH_IDX_W = 4;

    function automatic int flat_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dma_ch_sched_if.sv
// -----------------------------------------------------------------------------
// dma_ch_sched_if
// Command / completion channel between the scheduler and the AXI address stage.
//   cmd_valid/cmd_ready : command handshake (scheduler -> AXI)
//   cmd_rd              : 1 = read burst (AR), 0 = write burst (AW)
//   cmd_addr/cmd_len    : burst start address and AXI len (len-1 encoding)
//   cmd_id              : issuing channel index, used as AXI ID
//   done_valid/done_id  : burst completion (last R beat or B response)
// Modports: master = scheduler side, slave = AXI side.
// -----------------------------------------------------------------------------
interface dma_ch_sched_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    import dma_sched_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_rd;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic [CH_IDX_W-1:0] cmd_id;
    logic                done_valid;
    logic [CH_IDX_W-1:0] done_id;

    modport master (
        output cmd_valid, cmd_rd, cmd_addr, cmd_len, cmd_id,
        input  cmd_ready, done_valid, done_id
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_len, cmd_id,
        output cmd_ready, done_valid, done_id
    );

endinterface

// File: rtl/dma_ch_sched_arb.sv
// -----------------------------------------------------------------------------
// dma_rr_arb
// Combinational round-robin priority picker.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this round
//   o_gnt   : one-hot winner (zero when no request)
//   o_idx   : winner index
//   o_valid : at least one request present
// The search starts at i_ptr and wraps from N-1 to 0.
// -----------------------------------------------------------------------------
module dma_rr_arb #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_sum;

    // Rotate so that bit 0 of w_rot is the channel at i_ptr; the first set
    // bit of w_rot is then the round-robin winner, offset by i_ptr.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N-1:0];

    // NOTE: every variable written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        w_sum   = '0;
        // Scan downward so the lowest set offset is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = (IW+1)'(k);
            end
        end
        w_sum = w_sum + {1'b0, i_ptr};
        if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
        end
    end

    assign o_idx = w_sum[IW-1:0];
    assign o_gnt = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/dma_ch_sched.sv
// -----------------------------------------------------------------------------
// dma_ch_sched
// Multi-channel DMA command scheduler in front of a single AXI64 master port.
// Picks one eligible channel per round (round-robin), holds its burst command
// on a valid/ready handshake, tracks per-channel in-flight bursts and a global
// outstanding count, and pulses the peripheral clear for paced channels.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   dma_en          : global enable; low blocks new arbitration
//   ch_req          : per-channel burst command pending (level)
//   ch_rd           : per-channel direction (1 = read)
//   ch_periph_en    : per-channel peripheral pacing enable
//   periph_req      : per-channel peripheral request
//   ch_addr, ch_len : flattened per-channel burst address / length
//   ch_gnt          : one-hot pulse on command acceptance
//   periph_clr      : pulse to the peripheral on acceptance (paced channels)
//   ch_busy         : channel has a burst in flight
//   idle            : no command held and nothing outstanding
//   err_spur_done   : sticky, completion seen for a non-busy channel
//   bus             : command/completion interface (master side)
// -----------------------------------------------------------------------------
module dma_ch_sched
    import dma_sched_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 4,
    parameter int MAX_OUTS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dma_en,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_rd,
    input  logic [NUM_CH-1:0]        ch_periph_en,
    input  logic [NUM_CH-1:0]        periph_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        periph_clr,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic                     idle,
    output logic                     err_spur_done,
    dma_ch_sched_if.master           bus
);

    localparam int IW    = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    // ---------------------------------------------------------------- state
    state_e              r_state;
    state_e              w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_CH-1:0]   r_busy;
    logic [NUM_CH-1:0]   w_busy_nxt;
    logic                r_cmd_rd;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [LEN_W-1:0]    r_cmd_len;
    logic [IW-1:0]       r_sel_idx;
    logic [NUM_CH-1:0]   r_sel_onehot;
    logic [NUM_CH-1:0]   r_gnt;
    logic [NUM_CH-1:0]   r_clr;
    logic                r_idle;
    logic                r_err;

    // ---------------------------------------------------------------- wires
    logic [ADDR_W-1:0]   w_addr_arr [NUM_CH];
    logic [LEN_W-1:0]    w_len_arr  [NUM_CH];
    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_arb_gnt;
    logic [IW-1:0]       w_arb_idx;
    logic                w_arb_valid;
    logic                w_arb_go;
    logic                w_load;
    logic                w_accept;
    logic                w_cmd_valid;
    logic [NUM_CH-1:0]   w_done_mask;
    logic [NUM_CH-1:0]   w_done_clr;
    logic                w_done_hit;
    logic                w_spur;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addr_arr[g] = ch_addr[flat_lo(g, ADDR_W) +: ADDR_W];
        assign w_len_arr[g]  = ch_len[flat_lo(g, LEN_W) +: LEN_W];
    end

    // A paced channel is only eligible while its peripheral asks for data;
    // a channel with a burst already in flight waits for its completion.
    assign w_elig = ch_req & ~r_busy & (~ch_periph_en | periph_req);

    dma_rr_arb #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_arb_go = dma_en && (r_out_cnt < CNT_W'(MAX_OUTS)) && w_arb_valid;

    // ------------------------------------------------------- FSM: register
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------- FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_go)      w_state_nxt = ISSUE;
            ISSUE:   if (bus.cmd_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------- FSM: outputs
    // The command is held for the whole ISSUE state; it is never withdrawn
    // once presented, whatever dma_en or ch_req do meanwhile.
    always_comb begin
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_cmd_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = w_arb_go;
            end
            ISSUE: begin
                w_cmd_valid = 1'b1;
                w_accept    = bus.cmd_ready;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- completion
    // Match done_id against each channel explicitly so ids >= NUM_CH simply
    // hit nothing and fall through to the spurious path.
    always_comb begin
        w_done_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_done_mask[i] = bus.done_valid && (bus.done_id == CH_IDX_W'(i));
        end
    end

    assign w_done_clr = w_done_mask & r_busy;
    assign w_done_hit = |w_done_clr;
    assign w_spur     = bus.done_valid && !w_done_hit;

    // The accepting channel cannot be busy, so setting its bit and clearing a
    // completing one never collide on the same channel.
    assign w_busy_nxt = (r_busy & ~w_done_clr) | (w_accept ? r_sel_onehot : '0);

    // Accept and completion in the same cycle cancel out.
    always_comb begin
        w_cnt_nxt = r_out_cnt;
        if (w_accept && !w_done_hit) begin
            if (r_out_cnt < CNT_W'(MAX_OUTS)) begin
                w_cnt_nxt = r_out_cnt + CNT_W'(1);
            end
        end else if (!w_accept && w_done_hit) begin
            if (r_out_cnt != '0) begin
                w_cnt_nxt = r_out_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_out_cnt    <= '0;
            r_busy       <= '0;
            r_cmd_rd     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_sel_idx    <= '0;
            r_sel_onehot <= '0;
            r_gnt        <= '0;
            r_clr        <= '0;
            r_idle       <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            r_out_cnt <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_gnt     <= w_accept ? r_sel_onehot : '0;
            r_clr     <= w_accept ? (r_sel_onehot & ch_periph_en) : '0;
            // Registered from next-state values so idle lines up with the
            // state and count it describes.
            r_idle    <= (w_state_nxt == IDLE) && (w_cnt_nxt == '0);

            if (w_spur) begin
                r_err <= 1'b1;
            end

            if (w_load) begin
                r_cmd_rd     <= ch_rd[w_arb_idx];
                r_cmd_addr   <= w_addr_arr[w_arb_idx];
                r_cmd_len    <= w_len_arr[w_arb_idx];
                r_sel_idx    <= w_arb_idx;
                r_sel_onehot <= w_arb_gnt;
            end

            // Next round starts searching just after the accepted channel.
            if (w_accept) begin
                r_rr_ptr <= (r_sel_idx == IW'(NUM_CH - 1)) ? '0 : r_sel_idx + IW'(1);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.cmd_valid  = w_cmd_valid;
    assign bus.cmd_rd     = r_cmd_rd;
    assign bus.cmd_addr   = r_cmd_addr;
    assign bus.cmd_len    = r_cmd_len;
    assign bus.cmd_id     = CH_IDX_W'(r_sel_idx);
    assign ch_gnt         = r_gnt;
    assign periph_clr     = r_clr;
    assign ch_busy        = r_busy;
    assign idle           = r_idle;
    assign err_spur_done  = r_err;

endmodule

// File: tb/tb_dma_ch_sched.sv
// -----------------------------------------------------------------------------
// tb_dma_ch_sched
// Self-checking bench for dma_ch_sched. A transaction-level reference model
// (held command, busy set, outstanding count, round-robin pointer, sticky
// error) is advanced once per clock from the documented rules and compared
// against every DUT output on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_ch_sched;

    localparam int NUM_CH   = 8;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 4;
    localparam int MAX_OUTS = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     dma_en;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_rd;
    logic [NUM_CH-1:0]        ch_periph_en;
    logic [NUM_CH-1:0]        periph_req;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        periph_clr;
    logic [NUM_CH-1:0]        ch_busy;
    logic                     idle;
    logic                     err_spur_done;

    dma_ch_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    dma_ch_sched #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .MAX_OUTS (MAX_OUTS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dma_en        (dma_en),
        .ch_req        (ch_req),
        .ch_rd         (ch_rd),
        .ch_periph_en  (ch_periph_en),
        .periph_req    (periph_req),
        .ch_addr       (ch_addr),
        .ch_len        (ch_len),
        .ch_gnt        (ch_gnt),
        .periph_clr    (periph_clr),
        .ch_busy       (ch_busy),
        .idle          (idle),
        .err_spur_done (err_spur_done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    bit                m_pend;
    bit                m_rd;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    int                m_id;
    int                m_outs;
    int                m_ptr;
    bit                m_err;
    bit [NUM_CH-1:0]   m_busy;
    bit [NUM_CH-1:0]   m_gnt;
    bit [NUM_CH-1:0]   m_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_gnt_seen;
    int q_ids[$];

    task automatic model_reset();
        m_pend = 0; m_rd = 0; m_addr = '0; m_len = '0; m_id = 0;
        m_outs = 0; m_ptr = 0; m_err = 0;
        m_busy = '0; m_gnt = '0; m_clr = '0;
    endtask

    function automatic bit eligible(int c);
        return ch_req[c] && !m_busy[c] && (!ch_periph_en[c] || periph_req[c]);
    endfunction

    function automatic int first_busy();
        for (int c = 0; c < NUM_CH; c++) if (m_busy[c]) return c;
        return 0;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("cmd_valid", 64'(bus.cmd_valid), 64'(m_pend));
        if (m_pend) begin
            check("cmd_id",   64'(bus.cmd_id),   64'(m_id));
            check("cmd_rd",   64'(bus.cmd_rd),   64'(m_rd));
            check("cmd_addr", 64'(bus.cmd_addr), 64'(m_addr));
            check("cmd_len",  64'(bus.cmd_len),  64'(m_len));
        end
        check("ch_gnt",        64'(ch_gnt),        64'(m_gnt));
        check("periph_clr",    64'(periph_clr),    64'(m_clr));
        check("ch_busy",       64'(ch_busy),       64'(m_busy));
        check("idle",          64'(idle),          64'(!m_pend && m_outs == 0));
        check("err_spur_done", 64'(err_spur_done), 64'(m_err));
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_gnt[c]) begin
                q_ids.push_back(c);
                n_gnt_seen++;
            end
        end
    endtask

    // One clock: predict from the pre-edge inputs, let the edge happen,
    // then compare on the falling edge.
    task automatic cycle();
        bit              acc;
        int              win;
        bit [NUM_CH-1:0] nb;
        int              no;
        acc = m_pend && bus.cmd_ready;
        win = -1;
        if (!m_pend && dma_en && m_outs < MAX_OUTS) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CH;
                if (win < 0 && eligible(c)) win = c;
            end
        end
        nb = m_busy;
        no = m_outs;
        m_gnt = '0;
        m_clr = '0;
        if (bus.done_valid) begin
            if (int'(bus.done_id) < NUM_CH && m_busy[bus.done_id]) begin
                nb[bus.done_id] = 1'b0;
                no--;
            end else begin
                m_err = 1;
            end
        end
        if (acc) begin
            nb[m_id]    = 1'b1;
            no++;
            m_gnt[m_id] = 1'b1;
            m_clr[m_id] = ch_periph_en[m_id];
            m_ptr       = (m_id + 1) % NUM_CH;
            m_pend      = 0;
        end
        if (win >= 0) begin
            m_pend = 1;
            m_id   = win;
            m_rd   = ch_rd[win];
            m_addr = ch_addr[win*ADDR_W +: ADDR_W];
            m_len  = ch_len[win*LEN_W +: LEN_W];
        end
        @(posedge clk);
        m_busy = nb;
        m_outs = (no > MAX_OUTS) ? MAX_OUTS : ((no < 0) ? 0 : no);
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c*ADDR_W +: ADDR_W] = $urandom;
            ch_len[c*LEN_W +: LEN_W]    = LEN_W'($urandom);
        end
        ch_rd = NUM_CH'($urandom);
    endtask

    task automatic quiet_inputs();
        dma_en         = 1'b1;
        ch_req         = '0;
        ch_periph_en   = '0;
        periph_req     = '0;
        bus.cmd_ready  = 1'b1;
        bus.done_valid = 1'b0;
        bus.done_id    = '0;
        rand_data();
    endtask

    // Complete every in-flight burst (and any held command) one at a time.
    task automatic drain();
        int k;
        k = 0;
        ch_req = '0;
        bus.cmd_ready = 1'b1;
        while ((m_busy != '0 || m_pend) && k < 40) begin
            bus.done_valid = (m_busy != '0);
            bus.done_id    = 4'(first_busy());
            cycle();
            k++;
        end
        bus.done_valid = 1'b0;
        cycle();
        check("drain_busy", 64'(ch_busy), 64'(0));
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        int                k;

        // ---------------------------------------------------------- reset
        reset = 1'b1;
        quiet_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_cmd_addr", 64'(bus.cmd_addr), 64'(0));
        check("rst_cmd_id",   64'(bus.cmd_id),   64'(0));
        check("rst_cmd_rd",   64'(bus.cmd_rd),   64'(0));
        check("rst_cmd_len",  64'(bus.cmd_len),  64'(0));
        reset = 1'b0;

        // -------------------------------- two requesters, ready always high
        ch_req = 8'h81;
        q_ids.delete();
        n_gnt_seen = 0;
        repeat (6) cycle();
        check("A_gnt_count", 64'(n_gnt_seen), 64'(2));
        check("A_first_id",  64'(q_ids[0]),   64'(0));
        check("A_second_id", 64'(q_ids[1]),   64'(7));
        check("A_busy",      64'(ch_busy),    64'(8'h81));
        drain();

        // ---------------------------------------- peripheral-paced channel
        ch_req = 8'h08;
        ch_periph_en = 8'h08;
        periph_req = 8'h00;
        n_gnt_seen = 0;
        repeat (10) cycle();
        check("B_blocked", 64'(n_gnt_seen), 64'(0));
        periph_req = 8'h08;
        repeat (3) cycle();
        check("B_gnt_count", 64'(n_gnt_seen),      64'(1));
        check("B_gnt_id",    64'(q_ids[$]),        64'(3));
        periph_req = '0;
        ch_periph_en = '0;
        drain();

        // ------------------------------------------- outstanding-limit cap
        ch_req = 8'hFF;
        n_gnt_seen = 0;
        repeat (14) cycle();
        check("C_cap",       64'(n_gnt_seen),    64'(MAX_OUTS));
        check("C_valid_low", 64'(bus.cmd_valid), 64'(0));
        bus.done_valid = 1'b1;
        bus.done_id = 4'(first_busy());
        cycle();
        bus.done_valid = 1'b0;
        repeat (2) cycle();
        check("C_fifth", 64'(n_gnt_seen), 64'(MAX_OUTS + 1));
        drain();

        // ---------------------- backpressure with dma_en dropping mid-way
        ch_req = 8'h20;
        bus.cmd_ready = 1'b0;
        exp_addr = ch_addr[5*ADDR_W +: ADDR_W];
        n_gnt_seen = 0;
        k = 0;
        while (!bus.cmd_valid && k < 5) begin
            cycle();
            k++;
        end
        check("D_valid_up", 64'(bus.cmd_valid), 64'(1));
        for (int i = 0; i < 20; i++) begin
            if (i == 10) dma_en = 1'b0;
            if (i == 15) ch_req = '0;
            rand_data();
            cycle();
        end
        check("D_valid_held", 64'(bus.cmd_valid), 64'(1));
        check("D_addr_held",  64'(bus.cmd_addr),  64'(exp_addr));
        bus.cmd_ready = 1'b1;
        ch_req = 8'h40;
        repeat (6) cycle();
        check("D_one_gnt", 64'(n_gnt_seen), 64'(1));
        check("D_gnt_id",  64'(q_ids[$]),   64'(5));
        dma_en = 1'b1;
        drain();

        // ------------------------------------------- spurious completions
        bus.done_valid = 1'b1;
        bus.done_id = 4'd5;
        cycle();
        bus.done_valid = 1'b0;
        check("E_err_set", 64'(err_spur_done), 64'(1));
        cycle();
        check("E_err_sticky", 64'(err_spur_done), 64'(1));
        ch_req = 8'h01;
        repeat (3) cycle();
        ch_req = 8'h02;
        bus.cmd_ready = 1'b0;
        repeat (2) cycle();
        bus.cmd_ready = 1'b1;
        bus.done_valid = 1'b1;
        bus.done_id = 4'd0;
        cycle();
        bus.done_valid = 1'b0;
        ch_req = '0;
        check("E_busy_swap", 64'(ch_busy), 64'(8'h02));
        check("E_not_idle",  64'(idle),    64'(0));
        drain();

        // ------------------------------------------ async reset in ISSUE
        ch_req = 8'h04;
        repeat (3) cycle();
        ch_req = 8'h10;
        bus.cmd_ready = 1'b0;
        repeat (2) cycle();
        check("F_pre_valid", 64'(bus.cmd_valid), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("F_rst_valid", 64'(bus.cmd_valid),   64'(0));
        check("F_rst_busy",  64'(ch_busy),         64'(0));
        check("F_rst_idle",  64'(idle),            64'(1));
        check("F_rst_err",   64'(err_spur_done),   64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ch_req = 8'hFF;
        bus.cmd_ready = 1'b1;
        q_ids.delete();
        n_gnt_seen = 0;
        repeat (3) cycle();
        check("F_restart_id", 64'(q_ids[0]), 64'(0));
        drain();

        // ----------------------------------------------- random traffic
        for (int n = 0; n < 400; n++) begin
            dma_en        = ($urandom % 8) != 0;
            ch_req        = NUM_CH'($urandom);
            ch_periph_en  = NUM_CH'($urandom);
            periph_req    = NUM_CH'($urandom);
            bus.cmd_ready = ($urandom % 3) != 0;
            bus.done_valid = 1'b0;
            bus.done_id    = '0;
            if (m_busy != '0 && ($urandom % 2) == 1) begin
                int s;
                int pick;
                s = $urandom % NUM_CH;
                pick = -1;
                for (int j = 0; j < NUM_CH; j++) begin
                    if (pick < 0 && m_busy[(s + j) % NUM_CH]) pick = (s + j) % NUM_CH;
                end
                bus.done_valid = 1'b1;
                bus.done_id    = 4'(pick);
            end else if (($urandom % 16) == 0) begin
                bus.done_valid = 1'b1;
                bus.done_id    = 4'($urandom % 16);
            end
            rand_data();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
